mem_port_rr_arbiter: RTL

//   Shares one downstream memory port among NUM_REQ cache-side requesters, one transaction at a time.

---
 rtl/mem_port_rr_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_port_rr_arbiter.sv
// mem_port_rr_arbiter: round-robin sharing of one memory port among NUM_REQ requesters,
// one outstanding transaction at a time.
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   req_valid/ready/addr/we/wdata requester side; packed per requester, ready is one-hot accept
//   resp_valid, resp_rdata        one-hot response strobe to the owner, shared data (0 when idle)
//   mem_req_*                     downstream request, fields latched at accept
//   mem_resp_valid/rdata          downstream response, passed straight through to the owner
//   busy, grant_id                transaction in flight, index of current owner
module mem_port_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int GW        = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_rdata,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic                             mem_req_we,
    output logic [DATA_WIDTH-1:0]            mem_req_wdata,
    input  logic                             mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]            mem_resp_rdata,
    output logic                             busy,
    output logic [GW-1:0]                    grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]      masked;
    logic [GW-1:0]           winner;
    logic                    resp_fire;

    // Requesters below the last owner get first pick; fall back to the full set when none ask.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            masked[i] = req_valid[i] && (i < int'(last_q));
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if ((|masked) ? masked[i] : req_valid[i])
                winner = GW'(i);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                state_d = ISSUE;
                grant_d = winner;
                addr_d  = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                we_d    = req_we[winner];
                wdata_d = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            end
            ISSUE: if (mem_req_ready) state_d = WAIT_RESP;
            WAIT_RESP: if (mem_resp_valid) begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // req_ready is combinational from req_valid, so it is gated by rst_n to stay quiet in reset.
    assign req_ready     = (rst_n && state_q == IDLE && |req_valid) ? NUM_REQ'(1) << winner : '0;
    assign resp_fire     = state_q == WAIT_RESP && mem_resp_valid;
    assign resp_valid    = resp_fire ? NUM_REQ'(1) << grant_q : '0;
    assign resp_rdata    = resp_fire ? mem_resp_rdata : '0;
    assign mem_req_valid = state_q == ISSUE;
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;
    assign busy          = state_q != IDLE;
    assign grant_id      = grant_q;
endmodule
